// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the MiniMIPS32 pipeline controller: exception codes,
// stall-vector encodings and the stall priority encoder.
package pipe_ctrl_pkg;

    localparam int EXC_CODE_WIDTH = 5;

    localparam logic [EXC_CODE_WIDTH-1:0] EC_NONE    = 5'h10;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_ERET    = 5'h11;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_SYSCALL = 5'h08;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // Bit order: [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB; WB is never frozen.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    function automatic logic [5:0] stall_encode(
        input logic req_if,
        input logic req_id,
        input logic req_ex,
        input logic req_mem
    );
        logic [5:0] enc;
        enc = STALL_NONE;
        if (req_mem)     enc = STALL_MEM;
        else if (req_ex) enc = STALL_EX;
        else if (req_id) enc = STALL_ID;
        else if (req_if) enc = STALL_IF;
        return enc;
    endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Stall-cycle and flush-event counters; instantiated only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl_perf #(
    parameter int PERF_W = 32
) (
    input  logic              cpu_clk_75M,
    input  logic              cpu_rst_n,
    input  logic [5:0]        stall,
    input  logic              flush,
    output logic [PERF_W-1:0] perf_stall_cycles,
    output logic [PERF_W-1:0] perf_flush_count
);

    // Counters wrap naturally at 2^PERF_W.
    always_ff @(posedge cpu_clk_75M) begin
        if (!cpu_rst_n) begin
            perf_stall_cycles <= '0;
            perf_flush_count  <= '0;
        end else begin
            if (stall != 6'b000000)
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
            if (flush)
                perf_flush_count <= perf_flush_count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush scheduler for the 5-stage MiniMIPS32 pipeline: merges stall
// requests and sequences exception/ERET redirects. Optional counters: PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380,
    parameter int          HOLD_CYCLES = 2,
    parameter int          PERF_W      = 32
) (
    input  logic                      cpu_clk_75M,
    input  logic                      cpu_rst_n,
    input  logic                      stallreq_if,
    input  logic                      stallreq_id,
    input  logic                      stallreq_ex,
    input  logic                      stallreq_mem,
    input  logic [EXC_CODE_WIDTH-1:0] exc_code_i,
    input  logic [31:0]               cp0_epc_i,
`ifdef PIPE_CTRL_PERF_EN
    output logic [PERF_W-1:0]         perf_stall_cycles,
    output logic [PERF_W-1:0]         perf_flush_count,
`endif
    output logic [5:0]                stall,
    output logic                      flush,
    output logic [31:0]               new_pc,
    output logic                      busy_exc
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  hold_q, hold_d;
    logic [31:0] target_q, target_d;

    logic [5:0]  stall_enc, stall_c;
    logic        flush_c;
    logic [31:0] new_pc_c, target_now;
    logic        exc_req;

    always_comb begin
        stall_enc  = stall_encode(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
        exc_req    = (exc_code_i != EC_NONE);
        target_now = (exc_code_i == EC_ERET) ? cp0_epc_i : EXC_VECTOR;

        stall_c  = stall_enc;
        flush_c  = 1'b0;
        new_pc_c = ZERO_WORD;
        state_d  = state_q;
        hold_d   = hold_q;
        target_d = target_q;

        case (state_q)
            RUN: begin
                if (exc_req) begin
                    if (!stallreq_mem) begin
                        flush_c  = 1'b1;
                        new_pc_c = target_now;
                        stall_c  = STALL_NONE;
                        state_d  = HOLD;
                        hold_d   = HOLD_INIT;
                    end else begin
                        target_d = target_now;
                        state_d  = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The committed exception is already captured; new codes are ignored.
                if (!stallreq_mem) begin
                    flush_c  = 1'b1;
                    new_pc_c = target_q;
                    stall_c  = STALL_NONE;
                    state_d  = HOLD;
                    hold_d   = HOLD_INIT;
                end
            end
            HOLD: begin
                if (hold_q == 4'd0)
                    state_d = RUN;
                else
                    hold_d = hold_q - 4'd1;
            end
            default: state_d = RUN;
        endcase
    end

    // Outputs are forced quiet while reset is held, independent of state.
    assign stall    = cpu_rst_n ? stall_c  : STALL_NONE;
    assign flush    = cpu_rst_n & flush_c;
    assign new_pc   = cpu_rst_n ? new_pc_c : ZERO_WORD;
    assign busy_exc = cpu_rst_n & (state_q != RUN);

    always_ff @(posedge cpu_clk_75M) begin
        if (!cpu_rst_n) begin
            state_q  <= RUN;
            hold_q   <= 4'd0;
            target_q <= ZERO_WORD;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            target_q <= target_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    pipe_ctrl_perf #(
        .PERF_W (PERF_W)
    ) u_perf (
        .cpu_clk_75M       (cpu_clk_75M),
        .cpu_rst_n         (cpu_rst_n),
        .stall             (stall),
        .flush             (flush),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_count  (perf_flush_count)
    );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl: stall priority, exception/ERET
// sequencing, HOLD lockout and reset during DRAIN.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic                      cpu_clk_75M;
    logic                      cpu_rst_n;
    logic                      stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic [EXC_CODE_WIDTH-1:0] exc_code_i;
    logic [31:0]               cp0_epc_i;
    logic [5:0]                stall;
    logic                      flush;
    logic [31:0]               new_pc;
    logic                      busy_exc;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0]               perf_stall_cycles;
    logic [31:0]               perf_flush_count;
`endif

    int vec_cnt = 0;
    int mis_cnt = 0;
    logic [31:0] exp_q[$];

    pipe_ctrl dut (
        .cpu_clk_75M       (cpu_clk_75M),
        .cpu_rst_n         (cpu_rst_n),
        .stallreq_if       (stallreq_if),
        .stallreq_id       (stallreq_id),
        .stallreq_ex       (stallreq_ex),
        .stallreq_mem      (stallreq_mem),
        .exc_code_i        (exc_code_i),
        .cp0_epc_i         (cp0_epc_i),
`ifdef PIPE_CTRL_PERF_EN
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_count  (perf_flush_count),
`endif
        .stall             (stall),
        .flush             (flush),
        .new_pc            (new_pc),
        .busy_exc          (busy_exc)
    );

    // Clock / reset
    initial cpu_clk_75M = 1'b0;
    always #5 cpu_clk_75M = ~cpu_clk_75M;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, check the combinational outputs mid-cycle,
    // then advance past the next rising edge.
    task automatic cyc(
        input string       tag,
        input logic        r_if, r_id, r_ex, r_mem,
        input logic [4:0]  ec,
        input logic [31:0] epc,
        input logic [5:0]  e_stall,
        input logic        e_flush,
        input logic [31:0] e_pc,
        input logic        e_busy
    );
        stallreq_if  = r_if;
        stallreq_id  = r_id;
        stallreq_ex  = r_ex;
        stallreq_mem = r_mem;
        exc_code_i   = ec;
        cp0_epc_i    = epc;
        if (e_flush) exp_q.push_back(e_pc);
        #2;
        check({tag, ".stall"}, {26'd0, stall}, {26'd0, e_stall});
        check({tag, ".flush"}, {31'd0, flush}, {31'd0, e_flush});
        check({tag, ".new_pc"}, new_pc, e_pc);
        check({tag, ".busy"}, {31'd0, busy_exc}, {31'd0, e_busy});
        if (flush) begin
            if (exp_q.size() == 0)
                check({tag, ".unexpected_flush"}, 32'd1, 32'd0);
            else
                check({tag, ".redirect"}, new_pc, exp_q.pop_front());
        end
        @(posedge cpu_clk_75M);
        #1;
    endtask

    localparam logic [31:0] VEC = 32'hBFC0_0380;
    localparam logic [31:0] EPC = 32'h8000_1234;

    initial begin
        cpu_rst_n    = 1'b0;
        stallreq_if  = 1'b0;
        stallreq_id  = 1'b0;
        stallreq_ex  = 1'b0;
        stallreq_mem = 1'b0;
        exc_code_i   = EC_NONE;
        cp0_epc_i    = '0;
        #1;

        // Reset holds outputs quiet whatever the inputs are.
        cyc("rst0", 1, 1, 1, 1, EC_SYSCALL, EPC, 6'b000000, 0, 32'h0, 0);
        cyc("rst1", 1, 0, 1, 0, EC_ERET,    EPC, 6'b000000, 0, 32'h0, 0);
        cpu_rst_n = 1'b1;

        cyc("idle", 0, 0, 0, 0, EC_NONE, 32'h0, 6'b000000, 0, 32'h0, 0);

        // EX busy for exactly three cycles.
        for (int i = 0; i < 3; i++)
            cyc("ex_busy", 0, 0, 1, 0, EC_NONE, 32'h0, 6'b001111, 0, 32'h0, 0);
        cyc("ex_done", 0, 0, 0, 0, EC_NONE, 32'h0, 6'b000000, 0, 32'h0, 0);

        // Priority encoding.
        cyc("id_mem",  0, 1, 0, 1, EC_NONE, 32'h0, 6'b011111, 0, 32'h0, 0);
        cyc("if_only", 1, 0, 0, 0, EC_NONE, 32'h0, 6'b000011, 0, 32'h0, 0);
        cyc("id_only", 0, 1, 0, 0, EC_NONE, 32'h0, 6'b000111, 0, 32'h0, 0);
        cyc("if_ex",   1, 0, 1, 0, EC_NONE, 32'h0, 6'b001111, 0, 32'h0, 0);
        cyc("if_id",   1, 1, 0, 0, EC_NONE, 32'h0, 6'b000111, 0, 32'h0, 0);
        cyc("all",     1, 1, 1, 1, EC_NONE, 32'h0, 6'b011111, 0, 32'h0, 0);

        // Syscall with idle bus: immediate flush, flush beats stall, then 2 HOLD cycles
        // in which a second exception is ignored, then the re-raised one is taken.
        cyc("sys_flush",  0, 1, 1, 0, EC_SYSCALL, 32'h0, 6'b000000, 1, VEC, 0);
        cyc("sys_hold1",  0, 1, 0, 0, EC_SYSCALL, 32'h0, 6'b000111, 0, 32'h0, 1);
        cyc("sys_hold0",  0, 0, 0, 0, EC_SYSCALL, 32'h0, 6'b000000, 0, 32'h0, 1);
        cyc("sys_again",  0, 0, 0, 0, EC_SYSCALL, 32'h0, 6'b000000, 1, VEC, 0);
        cyc("sys2_hold1", 0, 0, 0, 0, EC_NONE,    32'h0, 6'b000000, 0, 32'h0, 1);
        cyc("sys2_hold0", 0, 0, 1, 0, EC_NONE,    32'h0, 6'b001111, 0, 32'h0, 1);
        cyc("sys2_run",   0, 0, 0, 0, EC_NONE,    32'h0, 6'b000000, 0, 32'h0, 0);

        // ERET behind a 4-cycle bus access; the latched EPC survives input changes.
        cyc("eret_m0", 0, 0, 0, 1, EC_ERET,    EPC,          6'b011111, 0, 32'h0, 0);
        cyc("eret_m1", 0, 0, 0, 1, EC_NONE,    32'hDEAD_BEEF, 6'b011111, 0, 32'h0, 1);
        cyc("eret_m2", 0, 1, 0, 1, EC_SYSCALL, 32'h0,        6'b011111, 0, 32'h0, 1);
        cyc("eret_m3", 1, 0, 1, 1, EC_ERET,    32'h1111_1111, 6'b011111, 0, 32'h0, 1);
        cyc("eret_fl", 0, 1, 0, 0, EC_NONE,    32'h0,        6'b000000, 1, EPC,   1);
        cyc("eret_h1", 0, 0, 0, 0, EC_NONE,    32'h0,        6'b000000, 0, 32'h0, 1);
        cyc("eret_h0", 0, 0, 0, 0, EC_NONE,    32'h0,        6'b000000, 0, 32'h0, 1);
        cyc("eret_run",0, 0, 0, 0, EC_NONE,    32'h0,        6'b000000, 0, 32'h0, 0);

        // ERET with idle bus redirects straight to the EPC input.
        cyc("eret_now", 0, 0, 0, 0, EC_ERET, 32'h0040_0100, 6'b000000, 1, 32'h0040_0100, 0);
        cyc("eret_nh1", 0, 0, 0, 0, EC_NONE, 32'h0,        6'b000000, 0, 32'h0, 1);
        cyc("eret_nh0", 0, 0, 0, 0, EC_NONE, 32'h0,        6'b000000, 0, 32'h0, 1);

        // Reset in DRAIN drops the pending exception.
        cyc("dr_enter", 0, 0, 0, 1, EC_SYSCALL, 32'h0, 6'b011111, 0, 32'h0, 0);
        cyc("dr_wait",  0, 0, 0, 1, EC_NONE,    32'h0, 6'b011111, 0, 32'h0, 1);
        cpu_rst_n = 1'b0;
        cyc("dr_rst",   0, 0, 0, 1, EC_NONE,    32'h0, 6'b000000, 0, 32'h0, 0);
        cpu_rst_n = 1'b1;
        cyc("dr_rel0",  0, 0, 0, 0, EC_NONE,    32'h0, 6'b000000, 0, 32'h0, 0);
        cyc("dr_rel1",  0, 0, 0, 0, EC_NONE,    32'h0, 6'b000000, 0, 32'h0, 0);

        check("flush_queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
